datapath_hs: RTL and testbench

//  Parametrised next-generation CPU datapath: register file, ALU operand muxes, PC/LR/SP/IR/ALUOUT/MDR

---
 rtl/datapath_hs_pkg.sv | 42 ++++
 rtl/datapath_hs_if.sv | 23 ++
 rtl/datapath_hs_regfile.sv | 37 +++
 rtl/datapath_hs.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_datapath_hs.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_hs_pkg.sv
// Shared types for the handshaked CPU datapath: ALU function codes, operand,
// immediate, write-data, PC and address selects, stack ops, memory FSM states
// and the ALU flag bundle. No logic lives here.
package dp_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,   // a + b
      ALU_ADC   = 4'd1,   // a + b + CFlag
      ALU_SUB   = 4'd2,   // a - b (C = no-borrow)
      ALU_SBC   = 4'd3,   // a + ~b + CFlag
      ALU_AND   = 4'd4,
      ALU_OR    = 4'd5,
      ALU_XOR   = 4'd6,
      ALU_NOT   = 4'd7,   // ~a
      ALU_SHL   = 4'd8,   // a << 1, C = shifted-out MSB
      ALU_SHR   = 4'd9,   // a >> 1 logical, C = shifted-out LSB
      ALU_ASR   = 4'd10,  // a >> 1 arithmetic, C = shifted-out LSB
      ALU_PASSA = 4'd11,
      ALU_PASSB = 4'd12
   } alu_func_t;

   typedef enum logic [1:0] {OP1_RD1 = 2'd0, OP1_PC = 2'd1, OP1_SP = 2'd2} op1_sel_t;
   typedef enum logic       {OP2_RD2 = 1'b0, OP2_IMM = 1'b1} op2_sel_t;
   typedef enum logic       {IMM_SHORT = 1'b0, IMM_LONG = 1'b1} imm_sel_t;
   typedef enum logic       {WD_MDR = 1'b0, WD_ALU = 1'b1} wd_sel_t;
   typedef enum logic [1:0] {PC_INC = 2'd0, PC_ALU = 2'd1, PC_LR = 2'd2, PC_MDR = 2'd3} pc_sel_t;
   typedef enum logic [1:0] {ADDR_PC = 2'd0, ADDR_ALUOUT = 2'd1, ADDR_SP = 2'd2} addr_sel_t;
   typedef enum logic [1:0] {SP_NONE = 2'd0, SP_PUSH = 2'd1, SP_POP = 2'd2} sp_op_t;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} mem_state_t;

   // Flag bundle in the order presented on the Flags port.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Width of the REQ-cycle timeout counter; TIMEOUT is limited to 1..255.
   localparam int TIMER_W = 8;

endpackage

// File: rtl/datapath_hs_if.sv
// Memory port between the datapath (master) and the memory/bus arbiter (slave).
// Req/ack handshake: address, write data and direction are held while MemReq=1;
// MemAck is a single-cycle pulse, MemRData is valid only in the MemAck cycle.
interface datapath_hs_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemWData;
   logic [DATA_W-1:0] MemRData;
   logic              MemReq;
   logic              MemWe;
   logic              MemAck;

   modport master (
      output MemAddr, MemWData, MemReq, MemWe,
      input  MemRData, MemAck
   );

   modport slave (
      input  MemAddr, MemWData, MemReq, MemWe,
      output MemRData, MemAck
   );
endinterface

// File: rtl/datapath_hs_regfile.sv
// General register file: NREGS x DATA_W, two asynchronous read ports, one write port.
// Latency: reads combinational, write lands on the rising edge; read-during-write sees the old value.
// Backpressure: none; the caller gates we_i.
// Ports: clk_i/rst_i (sync, active-high, clears all registers), we_i/waddr_i/wdata_i write port,
//        raddr1_i/raddr2_i -> rdata1_o/rdata2_o read ports.
module regfile_p #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       we_i,
   input  logic [$clog2(NREGS)-1:0]   waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [$clog2(NREGS)-1:0]   raddr1_i,
   input  logic [$clog2(NREGS)-1:0]   raddr2_i,
   output logic [DATA_W-1:0]          rdata1_o,
   output logic [DATA_W-1:0]          rdata2_o
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // NREGS is a power of two, so every index value addresses a real register.
   assign rdata1_o = regs_q[raddr1_i];
   assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/datapath_hs.sv
// CPU datapath: regfile, ALU + operand muxes, PC/LR/SP/IR/ALUOUT/MDR, req/ack memory port.
// Latency: one memory access takes >=3 cycles (launch, REQ until ack or TIMEOUT, DONE).
// Backpressure: Stall holds the control FSM during launch and REQ; architectural writes are gated.
// Ports: Clock, Reset (sync, active-high); mem (datapath_hs_if.master) memory handshake;
//        MemStart/MemRw/AddrSel launch control; AluOp/Op1Sel/Op2Sel/ImmSel/CFlag ALU control;
//        WdSel/PcSel/IrWe/PcWe/LrWe/RegWe/AluWe/SpOp register control;
//        Opcode=IR[15:8], Flags={N,Z,C,V}, Stall, sticky BusErr and StackErr.
module datapath_hs
   import dp_pkg::*;
#(
   parameter int          DATA_W   = 16,
   parameter int          NREGS    = 8,
   parameter logic [31:0] SP_RESET = 32'hFFFF,
   parameter logic [31:0] SP_LIMIT = 32'hFF00,
   parameter int          TIMEOUT  = 15
) (
   input  logic                 Clock,
   input  logic                 Reset,
   datapath_hs_if.master        mem,
   input  logic                 MemStart,
   input  logic                 MemRw,
   input  addr_sel_t            AddrSel,
   input  alu_func_t            AluOp,
   input  op1_sel_t             Op1Sel,
   input  op2_sel_t             Op2Sel,
   input  imm_sel_t             ImmSel,
   input  wd_sel_t              WdSel,
   input  pc_sel_t              PcSel,
   input  logic                 IrWe,
   input  logic                 PcWe,
   input  logic                 LrWe,
   input  logic                 RegWe,
   input  logic                 AluWe,
   input  sp_op_t               SpOp,
   input  logic                 CFlag,
   output logic [7:0]           Opcode,
   output logic [3:0]           Flags,
   output logic                 Stall,
   output logic                 BusErr,
   output logic                 StackErr
);

   localparam int                  RW       = $clog2(NREGS);
   localparam int                  M        = DATA_W - 1;
   localparam logic [DATA_W-1:0]   ONE      = DATA_W'(1);
   localparam logic [DATA_W-1:0]   SP_EMPTY = DATA_W'(SP_RESET);
   localparam logic [DATA_W-1:0]   SP_FLOOR = DATA_W'(SP_LIMIT);
   // The timer counts completed REQ cycles, so the TIMEOUT-th REQ cycle sees TIMEOUT-1.
   localparam logic [TIMER_W-1:0]  TMO_LAST = TIMER_W'(TIMEOUT - 1);

   // ---------------------------------------------------------------- state
   mem_state_t          state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                bus_err_q, bus_err_d;

   logic [DATA_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   lr_q, lr_d;
   logic [DATA_W-1:0]   sp_q, sp_d;
   logic [DATA_W-1:0]   aluout_q, aluout_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;
   // IR only ever needs the 16-bit instruction word (opcode, register fields, immediates).
   logic [15:0]         ir_q, ir_d;
   logic                stack_err_q, stack_err_d;

   // ---------------------------------------------------------------- nets
   logic                arch_we;
   logic                mem_req;
   logic [RW-1:0]       rs1, rs2;
   logic [DATA_W-1:0]   rd1, rd2;
   logic                rf_we;
   logic [DATA_W-1:0]   rf_wd;
   logic [DATA_W-1:0]   op_a, op_b, imm_v, b_add;
   logic [DATA_W:0]     sum;
   logic                cin;
   logic [DATA_W-1:0]   alu_res;
   flags_t              alu_flags;
   logic [DATA_W-1:0]   addr_mux;

   // ---------------------------------------------------------------- regfile
   assign rs1 = ir_q[8 +: RW];
   assign rs2 = ir_q[2 +: RW];

   assign rf_we = RegWe && arch_we;
   assign rf_wd = (WdSel == WD_MDR) ? mdr_q : aluout_q;

   regfile_p #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk_i    (Clock),
      .rst_i    (Reset),
      .we_i     (rf_we),
      .waddr_i  (rs1),
      .wdata_i  (rf_wd),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (rd1),
      .rdata2_o (rd2)
   );

   // ---------------------------------------------------------------- ALU
   always_comb begin
      case (Op1Sel)
         OP1_PC:  op_a = pc_q;
         OP1_SP:  op_a = sp_q;
         default: op_a = rd1;
      endcase
      // Size cast of a signed value sign-extends to DATA_W.
      imm_v = (ImmSel == IMM_LONG) ? DATA_W'($signed(ir_q[7:0]))
                                   : DATA_W'($signed(ir_q[4:0]));
      op_b  = (Op2Sel == OP2_IMM) ? imm_v : rd2;
   end

   // One adder serves all four arithmetic ops: subtraction is a + ~b + 1, so the
   // carry out means "no borrow" and the overflow rule applies to a and ~b.
   always_comb begin
      b_add = ((AluOp == ALU_SUB) || (AluOp == ALU_SBC)) ? ~op_b : op_b;
      case (AluOp)
         ALU_ADD: cin = 1'b0;
         ALU_SUB: cin = 1'b1;
         default: cin = CFlag;
      endcase
      sum = {1'b0, op_a} + {1'b0, b_add} + {{DATA_W{1'b0}}, cin};

      alu_res     = sum[M:0];
      alu_flags.c = 1'b0;
      alu_flags.v = 1'b0;
      case (AluOp)
         ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
            alu_res     = sum[M:0];
            alu_flags.c = sum[DATA_W];
            alu_flags.v = (op_a[M] == b_add[M]) && (sum[M] != op_a[M]);
         end
         ALU_AND:   alu_res = op_a & op_b;
         ALU_OR:    alu_res = op_a | op_b;
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_NOT:   alu_res = ~op_a;
         ALU_SHL: begin
            alu_res     = {op_a[M-1:0], 1'b0};
            alu_flags.c = op_a[M];
         end
         ALU_SHR: begin
            alu_res     = {1'b0, op_a[M:1]};
            alu_flags.c = op_a[0];
         end
         ALU_ASR: begin
            alu_res     = {op_a[M], op_a[M:1]};
            alu_flags.c = op_a[0];
         end
         ALU_PASSA: alu_res = op_a;
         ALU_PASSB: alu_res = op_b;
         default:   alu_res = sum[M:0];
      endcase
      alu_flags.n = alu_res[M];
      alu_flags.z = (alu_res == '0);
   end

   assign Flags = alu_flags;

   // ---------------------------------------------------------------- memory FSM
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (MemStart) state_d = REQ;
         REQ:     if (mem.MemAck || (timer_q == TMO_LAST)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req = (state_q == REQ);
      Stall   = ((state_q == IDLE) && MemStart) || (state_q == REQ);
   end

   // While stalled only MDR may change; everything else waits for DONE or IDLE.
   assign arch_we = !Stall;

   // Push presents the pre-decremented SP in the same cycle it is requested.
   always_comb begin
      case (AddrSel)
         ADDR_ALUOUT: addr_mux = aluout_q;
         ADDR_SP:     addr_mux = (SpOp == SP_PUSH) ? (sp_q - ONE) : sp_q;
         default:     addr_mux = pc_q;
      endcase
   end

   // Memory-side registers: launch latches, REQ timer, read capture and timeout flag.
   always_comb begin
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      timer_d   = timer_q;
      mdr_d     = mdr_q;
      bus_err_d = bus_err_q;
      case (state_q)
         IDLE: begin
            if (MemStart) begin
               addr_d  = addr_mux;
               wdata_d = rd2;
               we_d    = MemRw;
               timer_d = '0;
            end
         end
         REQ: begin
            timer_d = timer_q + TIMER_W'(1);
            if (mem.MemAck) begin
               if (!we_q) mdr_d = mem.MemRData;
            end else if (timer_q == TMO_LAST) begin
               bus_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- architectural registers
   always_comb begin
      pc_d        = pc_q;
      lr_d        = lr_q;
      ir_d        = ir_q;
      aluout_d    = aluout_q;
      sp_d        = sp_q;
      stack_err_d = stack_err_q;

      if (arch_we) begin
         if (PcWe) begin
            case (PcSel)
               PC_ALU:  pc_d = alu_res;
               PC_LR:   pc_d = lr_q;
               PC_MDR:  pc_d = mdr_q;
               default: pc_d = pc_q + ONE;
            endcase
         end
         if (LrWe)  lr_d     = pc_q + ONE;
         if (IrWe)  ir_d     = 16'(mdr_q);
         if (AluWe) aluout_d = alu_res;

         // Out-of-bounds stack ops leave SP alone and raise the sticky error.
         case (SpOp)
            SP_PUSH: begin
               if (sp_q == SP_FLOOR) stack_err_d = 1'b1;
               else                  sp_d        = sp_q - ONE;
            end
            SP_POP: begin
               if (sp_q == SP_EMPTY) stack_err_d = 1'b1;
               else                  sp_d        = sp_q + ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         timer_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         bus_err_q   <= 1'b0;
         pc_q        <= '0;
         lr_q        <= '0;
         sp_q        <= SP_EMPTY;
         aluout_q    <= '0;
         mdr_q       <= '0;
         ir_q        <= '0;
         stack_err_q <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         bus_err_q   <= bus_err_d;
         pc_q        <= pc_d;
         lr_q        <= lr_d;
         sp_q        <= sp_d;
         aluout_q    <= aluout_d;
         mdr_q       <= mdr_d;
         ir_q        <= ir_d;
         stack_err_q <= stack_err_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign mem.MemAddr  = addr_q;
   assign mem.MemWData = wdata_q;
   assign mem.MemWe    = we_q;
   assign mem.MemReq   = mem_req;
   assign Opcode       = ir_q[15:8];
   assign BusErr       = bus_err_q;
   assign StackErr     = stack_err_q;

endmodule

// File: tb/tb_datapath_hs.sv
// Directed bench for datapath_hs: reset state, read/write handshakes, timeout,
// ALU flags, PC wrap/link, stack bounds and reset during an access.
module tb_datapath_hs;
   import dp_pkg::*;

   localparam int DW = 16;
   localparam int NR = 8;

   localparam logic [DW-1:0] MAXPOS  = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MINNEG  = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] ALLONES = '1;
   localparam logic [DW-1:0] SP_E    = DW'(32'hFFFF);
   localparam logic [DW-1:0] SP_L    = DW'(32'hFF00);
   localparam int            NPUSH   = int'(SP_E - SP_L) - 1;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        MemStart, MemRw;
   addr_sel_t   AddrSel;
   alu_func_t   AluOp;
   op1_sel_t    Op1Sel;
   op2_sel_t    Op2Sel;
   imm_sel_t    ImmSel;
   wd_sel_t     WdSel;
   pc_sel_t     PcSel;
   logic        IrWe, PcWe, LrWe, RegWe, AluWe;
   sp_op_t      SpOp;
   logic        CFlag;
   logic [7:0]  Opcode;
   logic [3:0]  Flags;
   logic        Stall, BusErr, StackErr;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 Clock = ~Clock;

   datapath_hs_if #(.DATA_W(DW)) mem_if ();

   datapath_hs #(.DATA_W(DW), .NREGS(NR)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .mem      (mem_if),
      .MemStart (MemStart),
      .MemRw    (MemRw),
      .AddrSel  (AddrSel),
      .AluOp    (AluOp),
      .Op1Sel   (Op1Sel),
      .Op2Sel   (Op2Sel),
      .ImmSel   (ImmSel),
      .WdSel    (WdSel),
      .PcSel    (PcSel),
      .IrWe     (IrWe),
      .PcWe     (PcWe),
      .LrWe     (LrWe),
      .RegWe    (RegWe),
      .AluWe    (AluWe),
      .SpOp     (SpOp),
      .CFlag    (CFlag),
      .Opcode   (Opcode),
      .Flags    (Flags),
      .Stall    (Stall),
      .BusErr   (BusErr),
      .StackErr (StackErr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
   task automatic cyc();
      @(posedge Clock);
      #2;
   endtask

   task automatic ctl_idle();
      MemStart = 1'b0; MemRw = 1'b0; AddrSel = ADDR_PC;
      AluOp = ALU_ADD; Op1Sel = OP1_RD1; Op2Sel = OP2_RD2; ImmSel = IMM_SHORT;
      WdSel = WD_MDR; PcSel = PC_INC;
      IrWe = 1'b0; PcWe = 1'b0; LrWe = 1'b0; RegWe = 1'b0; AluWe = 1'b0;
      SpOp = SP_NONE; CFlag = 1'b0;
   endtask

   // Read at ADDR_PC with an immediate ack; returns in IDLE with MDR loaded.
   task automatic rd_access(input logic [DW-1:0] data);
      MemStart = 1'b1; MemRw = 1'b0; AddrSel = ADDR_PC;
      cyc();
      MemStart = 1'b0; mem_if.MemAck = 1'b1; mem_if.MemRData = data;
      cyc();
      mem_if.MemAck = 1'b0;
      cyc();
   endtask

   initial begin
      ctl_idle();
      Reset = 1'b1;
      mem_if.MemAck = 1'b0;
      mem_if.MemRData = '0;
      repeat (2) cyc();

      // Reset state
      chk("rst_memreq", mem_if.MemReq, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_buserr", BusErr, 0);
      chk("rst_stackerr", StackErr, 0);
      chk("rst_pc", dut.pc_q, 0);
      chk("rst_sp", dut.sp_q, SP_E);
      chk("rst_mdr", dut.mdr_q, 0);
      chk("rst_opcode", Opcode, 0);
      Reset = 1'b0;

      // 1: read at PC=0, ack on the second REQ cycle; PC_INC requested throughout
      MemStart = 1'b1; AddrSel = ADDR_PC; PcWe = 1'b1; PcSel = PC_INC;
      #1;
      chk("t1_launch_stall", Stall, 1);
      chk("t1_launch_req", mem_if.MemReq, 0);
      cyc();
      MemStart = 1'b0;
      chk("t1_req1_req", mem_if.MemReq, 1);
      chk("t1_req1_stall", Stall, 1);
      chk("t1_req1_addr", mem_if.MemAddr, 0);
      chk("t1_req1_we", mem_if.MemWe, 0);
      chk("t1_req1_pc", dut.pc_q, 0);
      cyc();
      mem_if.MemAck = 1'b1; mem_if.MemRData = 'h1234;
      chk("t1_req2_req", mem_if.MemReq, 1);
      chk("t1_req2_stall", Stall, 1);
      chk("t1_req2_pc", dut.pc_q, 0);
      cyc();
      mem_if.MemAck = 1'b0;
      chk("t1_done_req", mem_if.MemReq, 0);
      chk("t1_done_stall", Stall, 0);
      chk("t1_done_mdr", dut.mdr_q, 'h1234);
      chk("t1_done_pc", dut.pc_q, 0);
      cyc();
      PcWe = 1'b0;
      chk("t1_idle_pc", dut.pc_q, 1);

      // r0 <- 0xBEEF (IR=0 so Rw=0), then IR <- 0x0140 (Rs1=1, Rs2=0, imm long=0x40)
      rd_access('hBEEF);
      WdSel = WD_MDR; RegWe = 1'b1;
      cyc();
      RegWe = 1'b0;
      rd_access('h0140);
      IrWe = 1'b1;
      cyc();
      IrWe = 1'b0;
      chk("opcode_0140", Opcode, 8'h01);
      AluOp = ALU_ADD; Op1Sel = OP1_RD1; Op2Sel = OP2_IMM; ImmSel = IMM_LONG;
      #1;
      chk("flags_0_plus_40", Flags, 4'b0000);
      AluWe = 1'b1;
      cyc();
      AluWe = 1'b0;
      chk("aluout_40", dut.aluout_q, 'h40);

      // 2: write at ADDR_ALUOUT with Rd2=r0, immediate ack
      MemStart = 1'b1; MemRw = 1'b1; AddrSel = ADDR_ALUOUT;
      cyc();
      MemStart = 1'b0; mem_if.MemAck = 1'b1;
      chk("t2_req", mem_if.MemReq, 1);
      chk("t2_we", mem_if.MemWe, 1);
      chk("t2_addr", mem_if.MemAddr, 'h40);
      chk("t2_wdata", mem_if.MemWData, 'hBEEF);
      cyc();
      mem_if.MemAck = 1'b0;
      chk("t2_done_req", mem_if.MemReq, 0);
      chk("t2_done_addr", mem_if.MemAddr, 'h40);
      chk("t2_done_wdata", mem_if.MemWData, 'hBEEF);
      chk("t2_mdr_kept", dut.mdr_q, 'h0140);
      chk("t2_buserr", BusErr, 0);
      cyc();
      MemRw = 1'b0;

      // 3: no ack -> timeout after 15 REQ cycles
      MemStart = 1'b1; AddrSel = ADDR_PC;
      cyc();
      MemStart = 1'b0;
      n = 0;
      while (mem_if.MemReq === 1'b1 && n < 40) begin
         n++;
         cyc();
      end
      chk("t3_req_cycles", n, 15);
      chk("t3_buserr", BusErr, 1);
      chk("t3_mdr_kept", dut.mdr_q, 'h0140);
      cyc();

      // 5: r1 <- MAXPOS, IR <- 0x0141 (imm short=+1), ADD gives signed overflow
      rd_access(MAXPOS);
      WdSel = WD_MDR; RegWe = 1'b1;
      cyc();
      RegWe = 1'b0;
      rd_access('h0141);
      IrWe = 1'b1;
      cyc();
      IrWe = 1'b0;
      AluOp = ALU_ADD; Op1Sel = OP1_RD1; Op2Sel = OP2_IMM; ImmSel = IMM_SHORT;
      #1;
      chk("t5_flags_ovf", Flags, 4'b1001);
      AluWe = 1'b1; PcSel = PC_ALU; PcWe = 1'b1;
      cyc();
      AluWe = 1'b0; PcWe = 1'b0;
      chk("t5_pc_alu", dut.pc_q, MINNEG);
      WdSel = WD_ALU; RegWe = 1'b1;
      cyc();
      RegWe = 1'b0;
      #1;
      chk("t5_flags_neg", Flags, 4'b1000);
      AluOp = ALU_SUB;
      #1;
      chk("t5_flags_sub", Flags, 4'b0011);
      AluOp = ALU_ADD;

      // PC wrap, link and return
      rd_access(ALLONES);
      PcSel = PC_MDR; PcWe = 1'b1;
      cyc();
      chk("pc_mdr", dut.pc_q, ALLONES);
      PcSel = PC_INC;
      cyc();
      PcWe = 1'b0;
      chk("pc_wrap", dut.pc_q, 0);
      LrWe = 1'b1;
      cyc();
      LrWe = 1'b0;
      chk("lr_link", dut.lr_q, 1);
      PcSel = PC_LR; PcWe = 1'b1;
      cyc();
      PcWe = 1'b0;
      chk("pc_lr", dut.pc_q, 1);

      // 4: push down to the limit, then overflow
      SpOp = SP_PUSH;
      repeat (NPUSH) cyc();
      SpOp = SP_NONE;
      chk("t4_sp_above_limit", dut.sp_q, SP_L + 1);
      chk("t4_no_err_yet", StackErr, 0);
      MemStart = 1'b1; MemRw = 1'b1; AddrSel = ADDR_SP; SpOp = SP_PUSH;
      cyc();
      MemStart = 1'b0; mem_if.MemAck = 1'b1;
      chk("t4_push_addr", mem_if.MemAddr, SP_L);
      chk("t4_sp_held_launch", dut.sp_q, SP_L + 1);
      cyc();
      mem_if.MemAck = 1'b0;
      chk("t4_sp_held_req", dut.sp_q, SP_L + 1);
      cyc();
      chk("t4_sp_limit", dut.sp_q, SP_L);
      chk("t4_err_clear", StackErr, 0);
      cyc();
      chk("t4_sp_overflow_hold", dut.sp_q, SP_L);
      chk("t4_err_overflow", StackErr, 1);
      SpOp = SP_POP; MemRw = 1'b0;
      cyc();
      SpOp = SP_NONE;
      chk("t4_pop", dut.sp_q, SP_L + 1);

      // 6: reset during REQ, late ack ignored; then pop from empty stack
      MemStart = 1'b1; AddrSel = ADDR_PC;
      cyc();
      MemStart = 1'b0;
      chk("t6_in_req", mem_if.MemReq, 1);
      Reset = 1'b1;
      cyc();
      chk("t6_req_dropped", mem_if.MemReq, 0);
      chk("t6_stall", Stall, 0);
      chk("t6_buserr_cleared", BusErr, 0);
      chk("t6_stackerr_cleared", StackErr, 0);
      chk("t6_sp_reset", dut.sp_q, SP_E);
      Reset = 1'b0; mem_if.MemAck = 1'b1; mem_if.MemRData = 'hAAAA;
      cyc();
      mem_if.MemAck = 1'b0;
      chk("t6_late_ack_mdr", dut.mdr_q, 0);
      chk("t6_late_ack_req", mem_if.MemReq, 0);
      SpOp = SP_POP;
      cyc();
      SpOp = SP_NONE;
      chk("t4_underflow_err", StackErr, 1);
      chk("t4_underflow_sp", dut.sp_q, SP_E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
